zoom_addr_scanner: RTL and testbench
====================================

# zoom_addr_scanner

Sequential, parametrised successor to the combinational zoom/address unit. On a `start` pulse it walks every destination pixel of a `SRC_W`×`SRC_H` frame in raster order. For each pixel it computes the centre-anchored source coordinate for a power-of-two zoom in or out, and emits the framebuffer read address through a 3-stage pipeline with a valid/ready handshake. It sits between the VGA/frame controller and the image memory read port.

## Interface
- `SRC_W`, 320, image width in pixels (even)
- `SRC_H`, 240, image height in pixels (even)
- `COORD_W`, 10, coordinate width; must satisfy 2^COORD_W > max(SRC_W, SRC_H)
- `ADDR_W`, 17, address width; must satisfy 2^ADDR_W ≥ SRC_W·SRC_H
- `MAX_LOG2`, 2, largest zoom exponent supported

Ports:
- `clock`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to scan a frame; ignored while `busy`
- `zoom_in`  in  1  1 = magnify, 0 = minify; sampled with `start`
- `zoom_log2`  in  2  zoom exponent k (factor 2^k); sampled with `start`; values above `MAX_LOG2` saturate to `MAX_LOG2`
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse after the last pixel is accepted
- `pix_valid`  out  1  output beat valid
- `pix_ready`  in  1  consumer accepts the beat
- `pix_x`  out  COORD_W  destination x
- `pix_y`  out  COORD_W  destination y
- `pix_addr`  out  ADDR_W  source address sy·SRC_W+sx (0 when blank)
- `pix_blank`  out  1  source coordinate lies outside the image

## Operation
- FSM has three states:
  - IDLE: `start` latches `zoom_in` and the saturated k, clears the counters dx = dy = 0, and moves to SCAN.
  - SCAN: issues one coordinate per advancing cycle. dx wraps SRC_W−1 → 0 and increments dy. After (SRC_W−1, SRC_H−1) is issued, moves to DRAIN.
  - DRAIN: waits until the pipeline is empty, pulses `done`, returns to IDLE.
- Stage 1 (counters) registers dx and dy.
- Stage 2 computes the offsets and source coordinates in signed arithmetic of width COORD_W+MAX_LOG2+2:
  - ox = dx − SRC_W/2, oy = dy − SRC_H/2.
  - Magnify: sx = SRC_W/2 + (ox >>> k), sy = SRC_H/2 + (oy >>> k); `>>>` is an arithmetic shift, flooring toward −∞.
  - Minify: sx = SRC_W/2 + (ox <<< k), sy = SRC_H/2 + (oy <<< k).
  - k = 0 is identity for both values of `zoom_in`.
- Stage 3 computes blank = (sx<0)|(sx≥SRC_W)|(sy<0)|(sy≥SRC_H), then addr = blank ? 0 : sy·SRC_W+sx. It registers `pix_*`.
- Backpressure uses a global stall: when `pix_valid`=1 and `pix_ready`=0, every stage, the counters and the FSM hold, and all `pix_*` outputs stay stable.
- `start` asserted while `busy` has no effect; zoom parameters never change mid-frame.
- Exactly SRC_W·SRC_H beats are emitted per frame, with no gaps when `pix_ready` is held at 1.

## Timing
- Reset values: `busy`, `done`, `pix_valid`, `pix_blank` = 0; `pix_x`, `pix_y`, `pix_addr` = 0; FSM in IDLE.
- `start` sampled at edge E0 drives `busy`=1 after E0. The first `pix_valid`=1 appears after E3, giving 3-cycle latency.
- With `pix_ready`=1 throughout, the last beat is valid after E(2+SRC_W·SRC_H). `done`=1 and `busy`=0 follow on the next edge, lasting one cycle.
- A `start` in the same cycle that `done` is high is ignored; a new frame can be requested from the following cycle.
- `reset_n` low mid-frame aborts immediately: all outputs return to reset values, no `done` is issued, and the in-flight beat is discarded.

## Configuration
- `ZOOM_SCAN_CLAMP_EN` defined:
  - out-of-range sx/sy are clamped to [0, SRC_W−1] and [0, SRC_H−1];
  - `pix_blank` is tied to 0 and `pix_addr` is always the clamped address.
- Undefined: blanking behaviour as specified under Operation.

## Test plan
- Reset, then 1x (`zoom_log2`=0), `pix_ready`=1 -> 76800 beats; first beat (0,0) gives addr 0; last beat (319,239) gives addr 76799; no blanks; `done` pulses once one cycle after the last beat.
- Zoom in 2x -> dest (0,0) gives addr 19280 (sx=80, sy=60); dest (319,239) gives addr 57519 (sx=239, sy=179); no blanks.
- Zoom out 2x -> dest (0,0) gives blank=1, addr 0; dest (80,60) gives blank=0, addr 0; dest (160,120) gives addr 38560; dest (240,180) gives blank=1.
- Backpressure: drop `pix_ready` for 5 cycles while beat (10,3) is valid -> `pix_*` stable for those 5 cycles; no beat is lost or duplicated; total beat count is 76800.
- Second `start` pulsed mid-frame with different `zoom_log2` -> ignored, current mode is unchanged. `reset_n` pulsed at beat 1000 -> outputs return to 0 and no `done` is issued; the next `start` scans a full frame.
- With `ZOOM_SCAN_CLAMP_EN`, zoom out 2x -> dest (0,0) gives addr 0 with blank=0; dest (319,239) gives addr 76799 (478 clamped to 319, 358 clamped to 239).

Source files
------------

// File: rtl/zoom_addr_scanner.sv
// -----------------------------------------------------------------------------
// zoom_addr_scanner
//
// Purpose: raster-scans every destination pixel of a SRC_W x SRC_H frame after
// a start request. For each pixel it computes a centre-anchored source
// coordinate for a power-of-two zoom in or out. It emits the framebuffer read
// address through a 3-stage pipeline with a valid/ready handshake.
//
// Optional feature macro: ZOOM_SCAN_CLAMP_EN
//   defined   -> out-of-range source coordinates are clamped to the image edge,
//                pix_blank is tied low and pix_addr is always the clamped address
//   undefined -> out-of-range source coordinates raise pix_blank with address 0
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   one-cycle frame request (ignored while busy or while done)
//   zoom_in    in   1 = magnify, 0 = minify (sampled with start)
//   zoom_log2  in   zoom exponent k, saturated to MAX_LOG2 (sampled with start)
//   busy       out  frame in progress
//   done       out  one-cycle pulse once the last beat has been accepted
//   pix_valid  out  output beat valid
//   pix_ready  in   consumer accepts the beat
//   pix_x      out  destination x
//   pix_y      out  destination y
//   pix_addr   out  source address sy*SRC_W+sx (0 when blank)
//   pix_blank  out  source coordinate lies outside the image
// -----------------------------------------------------------------------------
module zoom_addr_scanner #(
  parameter int SRC_W    = 320,
  parameter int SRC_H    = 240,
  parameter int COORD_W  = 10,
  parameter int ADDR_W   = 17,
  parameter int MAX_LOG2 = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               zoom_in,
  input  logic [1:0]         zoom_log2,
  output logic               busy,
  output logic               done,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [ADDR_W-1:0]  pix_addr,
  output logic               pix_blank
);

  // Signed width wide enough for an offset shifted left by MAX_LOG2 plus the
  // re-centring addition.
  localparam int SW = COORD_W + MAX_LOG2 + 2;

  localparam logic [COORD_W-1:0]   LAST_X  = COORD_W'(SRC_W - 1);
  localparam logic [COORD_W-1:0]   LAST_Y  = COORD_W'(SRC_H - 1);
  localparam logic signed [SW-1:0] HALF_W  = SW'(SRC_W / 2);
  localparam logic signed [SW-1:0] HALF_H  = SW'(SRC_H / 2);
  localparam logic signed [SW-1:0] LIMIT_W = SW'(SRC_W);
  localparam logic signed [SW-1:0] LIMIT_H = SW'(SRC_H);
  localparam logic [1:0]           K_MAX   = 2'(MAX_LOG2);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic                 zoom_in_q, zoom_in_d;
  logic [1:0]           k_q, k_d;
  logic [COORD_W-1:0]   dx_q, dx_d;
  logic [COORD_W-1:0]   dy_q, dy_d;
  logic                 done_q, done_d;
  logic                 issue;
  logic                 advance;
  logic                 drain_empty;

  logic                 s1_valid_q;
  logic [COORD_W-1:0]   s1_dx_q, s1_dy_q;

  logic                 s2_valid_q;
  logic [COORD_W-1:0]   s2_dx_q, s2_dy_q;
  logic signed [SW-1:0] s2_sx_q, s2_sy_q;
  logic signed [SW-1:0] ox, oy, off_x, off_y, sx_d, sy_d;

  logic                 pix_valid_q;
  logic [COORD_W-1:0]   pix_x_q, pix_y_q;
  logic [ADDR_W-1:0]    pix_addr_q;
  logic                 pix_blank_q;
  logic [COORD_W-1:0]   sx_c, sy_c;
  logic                 blank_d;
  logic [ADDR_W-1:0]    addr_d;

  // A beat held on the output without acceptance freezes the whole design.
  assign advance = !(pix_valid_q && !pix_ready);

  // After this edge, the pipeline holds nothing once the output beat leaves and
  // no earlier stage is occupied.
  assign drain_empty = advance && !s1_valid_q && !s2_valid_q;

  // Next-state logic for the frame sequencer and the raster counters. The
  // counters only move on advancing cycles, so a stall freezes the scan. A start
  // coinciding with the done pulse is deliberately ignored.
  always_comb begin
    state_d   = state_q;
    zoom_in_d = zoom_in_q;
    k_d       = k_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    done_d    = 1'b0;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          state_d   = SCAN;
          zoom_in_d = zoom_in;
          k_d       = (zoom_log2 > K_MAX) ? K_MAX : zoom_log2;
          dx_d      = '0;
          dy_d      = '0;
        end
      end
      SCAN: begin
        issue = 1'b1;
        if (advance) begin
          if (dx_q == LAST_X) begin
            dx_d = '0;
            if (dy_q == LAST_Y) begin
              state_d = DRAIN;
            end else begin
              dy_d = dy_q + 1'b1;
            end
          end else begin
            dx_d = dx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer, zoom mode and raster counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      zoom_in_q <= 1'b0;
      k_q       <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      zoom_in_q <= zoom_in_d;
      k_q       <= k_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      done_q    <= done_d;
    end
  end

  // Stage-2 arithmetic: offsets from the frame centre are scaled and then
  // re-centred. The arithmetic right shift floors toward minus infinity, so
  // negative offsets round away from the centre.
  always_comb begin
    ox = $signed({{(SW-COORD_W){1'b0}}, s1_dx_q}) - HALF_W;
    oy = $signed({{(SW-COORD_W){1'b0}}, s1_dy_q}) - HALF_H;
    if (zoom_in_q) begin
      off_x = ox >>> k_q;
      off_y = oy >>> k_q;
    end else begin
      off_x = ox <<< k_q;
      off_y = oy <<< k_q;
    end
    sx_d = HALF_W + off_x;
    sy_d = HALF_H + off_y;
  end

  // Stage-3 range check and address formation. The low COORD_W bits of each
  // coordinate are only meaningful when that coordinate is in range. In the
  // blanking build, the blank flag masks the address whenever either coordinate
  // is out of range.
  always_comb begin
`ifdef ZOOM_SCAN_CLAMP_EN
    blank_d = 1'b0;
    if (s2_sx_q[SW-1]) begin
      sx_c = '0;
    end else if (s2_sx_q >= LIMIT_W) begin
      sx_c = LAST_X;
    end else begin
      sx_c = s2_sx_q[COORD_W-1:0];
    end
    if (s2_sy_q[SW-1]) begin
      sy_c = '0;
    end else if (s2_sy_q >= LIMIT_H) begin
      sy_c = LAST_Y;
    end else begin
      sy_c = s2_sy_q[COORD_W-1:0];
    end
`else
    blank_d = s2_sx_q[SW-1] || (s2_sx_q >= LIMIT_W) ||
              s2_sy_q[SW-1] || (s2_sy_q >= LIMIT_H);
    sx_c    = s2_sx_q[COORD_W-1:0];
    sy_c    = s2_sy_q[COORD_W-1:0];
`endif
    if (blank_d) begin
      addr_d = '0;
    end else begin
      addr_d = ADDR_W'(sy_c) * ADDR_W'(SRC_W) + ADDR_W'(sx_c);
    end
  end

  // Pipeline registers for all three stages. They share the global advance
  // enable, so a stalled output beat holds every stage in place. An empty
  // stage-2 slot clears the output fields, so idle outputs read as zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_dx_q     <= '0;
      s1_dy_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_dx_q     <= '0;
      s2_dy_q     <= '0;
      s2_sx_q     <= '0;
      s2_sy_q     <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_addr_q  <= '0;
      pix_blank_q <= 1'b0;
    end else if (advance) begin
      s1_valid_q  <= issue;
      s1_dx_q     <= dx_q;
      s1_dy_q     <= dy_q;
      s2_valid_q  <= s1_valid_q;
      s2_dx_q     <= s1_dx_q;
      s2_dy_q     <= s1_dy_q;
      s2_sx_q     <= sx_d;
      s2_sy_q     <= sy_d;
      pix_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        pix_x_q     <= s2_dx_q;
        pix_y_q     <= s2_dy_q;
        pix_addr_q  <= addr_d;
        pix_blank_q <= blank_d;
      end else begin
        pix_x_q     <= '0;
        pix_y_q     <= '0;
        pix_addr_q  <= '0;
        pix_blank_q <= 1'b0;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_addr  = pix_addr_q;
  assign pix_blank = pix_blank_q;

endmodule

// File: tb/tb_zoom_addr_scanner.sv
// -----------------------------------------------------------------------------
// tb_zoom_addr_scanner
//
// Purpose: self-checking bench for zoom_addr_scanner on a reduced 20x12 frame.
// Every accepted beat is compared with a reference model. The model derives the
// source pixel from the zoom rules using integer division and multiplication.
// A vector table of known pixel/address pairs is checked against beats captured
// per frame. Hand-written sequences cover the full-rate timing, backpressure, a
// start pulse ignored mid-frame, a start pulse ignored on done, and a reset
// abort. Honours ZOOM_SCAN_CLAMP_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_zoom_addr_scanner;

  localparam int W        = 20;
  localparam int H        = 12;
  localparam int COORD_W  = 6;
  localparam int ADDR_W   = 9;
  localparam int MAX_LOG2 = 2;
  localparam int N        = W * H;
`ifdef ZOOM_SCAN_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic               zoom_in = 1'b0;
  logic [1:0]         zoom_log2 = 2'd0;
  logic               busy;
  logic               done;
  logic               pix_valid;
  logic               pix_ready = 1'b0;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [ADDR_W-1:0]  pix_addr;
  logic               pix_blank;

  int checks = 0;
  int passes = 0;
  int firstValid;
  int doneCycle;
  int stallCycles;
  int frameBeats;
  int capAddr [N];
  int capBlank[N];

  typedef struct {
    bit       zin;
    bit [1:0] zl;
    int       x;
    int       y;
    int       addr;
    bit       blank;
  } vec_t;

  vec_t vecs[17];

  zoom_addr_scanner #(
    .SRC_W   (W),
    .SRC_H   (H),
    .COORD_W (COORD_W),
    .ADDR_W  (ADDR_W),
    .MAX_LOG2(MAX_LOG2)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .zoom_in  (zoom_in),
    .zoom_log2(zoom_log2),
    .busy     (busy),
    .done     (done),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_addr (pix_addr),
    .pix_blank(pix_blank)
  );

  // Free-running clock with a 10-unit period.
  always #5 clock = ~clock;

  // Compares one observed value against the expected value and records the result.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Scales one centre offset. Magnify divides by the zoom factor and floors
  // toward minus infinity. Minify multiplies by the zoom factor.
  function automatic int scaleOffset(input int o, input bit zin, input int k);
    int f;
    int q;
    f = 2 ** k;
    if (zin) begin
      q = o / f;
      if ((o % f != 0) && (o < 0)) q = q - 1;
      return q;
    end
    return o * f;
  endfunction

  // Reference model: destination pixel to source address and blank flag.
  task automatic refPixel(input bit zin, input int k, input int x, input int y,
                          output int addr, output bit blank);
    int sx;
    int sy;
    sx = W / 2 + scaleOffset(x - W / 2, zin, k);
    sy = H / 2 + scaleOffset(y - H / 2, zin, k);
    if (CLAMP) begin
      if (sx < 0) sx = 0;
      if (sx > W - 1) sx = W - 1;
      if (sy < 0) sy = 0;
      if (sy > H - 1) sy = H - 1;
    end
    blank = (sx < 0) || (sx >= W) || (sy < 0) || (sy >= H);
    addr  = blank ? 0 : sy * W + sx;
  endtask

  // Runs one frame: it pulses start and then acts as the consumer each cycle.
  // Outputs are sampled and pix_ready is driven on the falling edge. Options:
  // readyPct sets the random accept rate. stallIdx holds ready low for 5 cycles
  // on that beat. midStart fires a conflicting start mid-frame. abortAt applies
  // reset when that beat count is reached. doneStart fires start during done.
  task automatic applyStimulus(input bit zin, input bit [1:0] zl, input int readyPct,
                               input int stallIdx, input bit midStart, input int abortAt,
                               input bit doneStart);
    int k;
    int ea;
    bit eb;
    int ex;
    int ey;
    int doneSeen;
    bit finished;
    bit prevStall;
    logic [COORD_W-1:0] px;
    logic [ADDR_W-1:0]  pa;
    k = (zl > MAX_LOG2) ? MAX_LOG2 : int'(zl);
    frameBeats = 0; firstValid = -1; doneCycle = -1; stallCycles = 0;
    finished = 1'b0; prevStall = 1'b0; px = '0; pa = '0;
    for (int i = 0; i < N; i++) begin
      capAddr[i] = -1;
      capBlank[i] = -1;
    end
    @(negedge clock);
    start = 1'b1; zoom_in = zin; zoom_log2 = zl;
    @(negedge clock);
    start = 1'b0; zoom_in = 1'($urandom); zoom_log2 = 2'($urandom);
    checkOutput("busy after start", busy, 1);
    for (int c = 0; c < 20 * N + 100 && !finished; c++) begin
      if (abortAt >= 0 && frameBeats == abortAt) begin
        reset_n = 1'b0;
        #1;
        checkOutput("abort pix_valid", pix_valid, 0);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort pix_x", pix_x, 0);
        checkOutput("abort pix_y", pix_y, 0);
        checkOutput("abort pix_addr", pix_addr, 0);
        checkOutput("abort pix_blank", pix_blank, 0);
        @(negedge clock);
        reset_n = 1'b1;
        doneSeen = 0;
        for (int j = 0; j < 20; j++) begin
          @(negedge clock);
          if (done || pix_valid || busy) doneSeen++;
        end
        checkOutput("no done or activity after abort", doneSeen, 0);
        return;
      end
      if (done) begin
        doneCycle = c;
        finished = 1'b1;
      end else begin
        if (pix_valid && firstValid < 0) firstValid = c;
        if (prevStall) begin
          checkOutput("stall pix_valid stable", pix_valid, 1);
          checkOutput("stall pix_x stable", pix_x, px);
          checkOutput("stall pix_addr stable", pix_addr, pa);
        end
        if (midStart) begin
          start = (c == 40);
          if (c == 40) begin
            zoom_in = ~zin;
            zoom_log2 = (zl == 2'd0) ? 2'd2 : 2'd0;
          end
        end
        if (stallIdx == frameBeats && pix_valid && stallCycles < 5) begin
          pix_ready = 1'b0;
          stallCycles++;
        end else begin
          pix_ready = ($urandom_range(99) < readyPct);
        end
        if (pix_valid && pix_ready) begin
          ex = frameBeats % W;
          ey = frameBeats / W;
          refPixel(zin, k, ex, ey, ea, eb);
          checkOutput($sformatf("beat(%0d,%0d) x", ex, ey), pix_x, ex);
          checkOutput($sformatf("beat(%0d,%0d) y", ex, ey), pix_y, ey);
          checkOutput($sformatf("beat(%0d,%0d) addr", ex, ey), pix_addr, ea);
          checkOutput($sformatf("beat(%0d,%0d) blank", ex, ey), pix_blank, eb);
          if (frameBeats < N) begin
            capAddr[frameBeats] = int'(pix_addr);
            capBlank[frameBeats] = int'(pix_blank);
          end
          frameBeats++;
        end
        prevStall = pix_valid && !pix_ready;
        px = pix_x;
        pa = pix_addr;
        @(negedge clock);
      end
    end
    if (!finished) begin
      checks++;
      $display("[TB] FAIL frame timeout beats=%0d required=%0d", frameBeats, N);
      return;
    end
    checkOutput("frame beat count", frameBeats, N);
    checkOutput("busy low with done", busy, 0);
    if (doneStart) begin
      start = 1'b1; zoom_in = zin; zoom_log2 = zl;
      @(negedge clock);
      start = 1'b0;
    end else begin
      @(negedge clock);
    end
    checkOutput("done is one cycle", done, 0);
    checkOutput("idle after done", busy, 0);
    pix_ready = 1'b1;
  endtask

  initial begin
    // Known pixel/address pairs, grouped by zoom mode.
    vecs[0]  = '{1'b1, 2'd0, 0, 0, 0, 1'b0};
    vecs[1]  = '{1'b1, 2'd0, 19, 11, 239, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 7, 5, 107, 1'b0};
    vecs[3]  = '{1'b1, 2'd1, 0, 0, 65, 1'b0};
    vecs[4]  = '{1'b1, 2'd1, 19, 11, 174, 1'b0};
    vecs[5]  = '{1'b1, 2'd1, 1, 1, 65, 1'b0};
    vecs[6]  = '{1'b0, 2'd1, 0, 0, 0, !CLAMP};
    vecs[7]  = '{1'b0, 2'd1, 5, 3, 0, 1'b0};
    vecs[8]  = '{1'b0, 2'd1, 10, 6, 130, 1'b0};
    vecs[9]  = '{1'b0, 2'd1, 15, 9, CLAMP ? 239 : 0, !CLAMP};
    vecs[10] = '{1'b0, 2'd1, 14, 8, 218, 1'b0};
    vecs[11] = '{1'b1, 2'd2, 0, 0, 87, 1'b0};
    vecs[12] = '{1'b1, 2'd2, 19, 11, 152, 1'b0};
    vecs[13] = '{1'b1, 2'd3, 1, 1, 87, 1'b0};
    vecs[14] = '{1'b0, 2'd3, 7, 4, 0, !CLAMP};
    vecs[15] = '{1'b0, 2'd3, 8, 5, 42, 1'b0};
    vecs[16] = '{1'b0, 2'd3, 12, 7, 218, 1'b0};

    // Values held in reset.
    repeat (3) @(negedge clock);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset pix_valid", pix_valid, 0);
    checkOutput("reset pix_blank", pix_blank, 0);
    checkOutput("reset pix_x", pix_x, 0);
    checkOutput("reset pix_y", pix_y, 0);
    checkOutput("reset pix_addr", pix_addr, 0);
    reset_n = 1'b1;
    pix_ready = 1'b1;
    @(negedge clock);

    // Full-rate identity frame: 3-cycle latency, no gaps, and a start on done ignored.
    applyStimulus(1'b1, 2'd0, 100, -1, 1'b0, -1, 1'b1);
    checkOutput("first valid latency", firstValid, 3);
    checkOutput("done timing", doneCycle, N + 3);

    // Table vectors, one randomly backpressured frame per zoom mode.
    for (int i = 0; i < 17; i++) begin
      if (i == 0 || vecs[i].zin != vecs[i-1].zin || vecs[i].zl != vecs[i-1].zl)
        applyStimulus(vecs[i].zin, vecs[i].zl, 70, -1, 1'b0, -1, 1'b0);
      checkOutput($sformatf("vec%0d addr", i), capAddr[vecs[i].y * W + vecs[i].x], vecs[i].addr);
      checkOutput($sformatf("vec%0d blank", i), capBlank[vecs[i].y * W + vecs[i].x], 32'(vecs[i].blank));
    end

    // Five-cycle stall on beat (10,3).
    applyStimulus(1'b1, 2'd1, 100, 3 * W + 10, 1'b0, -1, 1'b0);
    checkOutput("stall length", stallCycles, 5);

    // Conflicting start mid-frame must not change the mode.
    applyStimulus(1'b0, 2'd1, 80, -1, 1'b1, -1, 1'b0);

    // Reset mid-frame aborts silently; the next frame is complete.
    applyStimulus(1'b1, 2'd2, 100, -1, 1'b0, 100, 1'b0);
    applyStimulus(1'b1, 2'd2, 90, -1, 1'b0, -1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
